// File: rtl/sysbus_pkg.sv
// Shared Sysbus constants, fetch-arbiter state encoding and the request tag builder.
package sysbus_pkg;

    localparam logic [3:0] SYSBUS_READ   = 4'b0001;
    localparam logic [0:0] SYSBUS_MEMORY = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_REQ   = 2'd1;
    localparam state_t ST_RESP  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Bit 0 carries the owner id so responses can be attributed to a requester.
    function automatic logic [12:0] build_tag(input logic owner_id);
        logic [12:0] tag;
        tag       = '0;
        tag[11:8] = SYSBUS_READ;
        tag[12]   = SYSBUS_MEMORY;
        tag[0]    = owner_id;
        return tag;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to rr_ptr.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = rr_ptr;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/sysbus_fetch_arbiter.sv
// Shares the Sysbus master port between instruction fetch (m0) and the load path (m1),
// one 64-byte line read in flight at a time.
//
// state    | meaning
// IDLE     | arbitrate between m0/m1, latch line address and owner
// REQ      | drive bus_reqcyc until bus_reqack
// RESP     | collect N_BEATS beats and route them to the owner
// DRAIN    | hold respack until the bus stops presenting beats
module sysbus_fetch_arbiter
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int N_BEATS        = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      m0_req_valid,
    input  logic [63:0]               m0_req_addr,
    output logic                      m0_req_ready,
    output logic                      m0_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] m0_resp_data,
    output logic                      m0_resp_last,

    input  logic                      m1_req_valid,
    input  logic [63:0]               m1_req_addr,
    output logic                      m1_req_ready,
    output logic                      m1_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] m1_resp_data,
    output logic                      m1_resp_last,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,

    output logic                      err_tag
);

    localparam int               CNT_W     = $clog2(N_BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

    state_t           state;
    logic             owner;
    logic             rr_ptr;
    logic [63:0]      line_addr;
    logic [CNT_W-1:0] beat_cnt;
    logic             gnt_valid;
    logic             gnt_id;
    logic [63:0]      sel_addr;
    logic             beat_last;
    logic             unused_bits;

    rr_arbiter2 u_rr_arbiter2 (
        .req0      (m0_req_valid),
        .req1      (m1_req_valid),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign sel_addr  = gnt_id ? m1_req_addr : m0_req_addr;
    assign beat_last = (beat_cnt == LAST_BEAT);

    assign bus_reqcyc = (state == ST_REQ);
    assign bus_req    = bus_reqcyc ? BUS_DATA_WIDTH'(line_addr) : '0;
    assign bus_reqtag = bus_reqcyc ? BUS_TAG_WIDTH'(build_tag(owner)) : '0;

    // Line offset bits and the upper response tag are don't-cares here.
    assign unused_bits = ^{m0_req_addr[5:0], m1_req_addr[5:0],
                           bus_resptag[BUS_TAG_WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= 1'b0;
            rr_ptr        <= 1'b0;
            line_addr     <= '0;
            beat_cnt      <= '0;
            m0_req_ready  <= 1'b0;
            m0_resp_valid <= 1'b0;
            m0_resp_data  <= '0;
            m0_resp_last  <= 1'b0;
            m1_req_ready  <= 1'b0;
            m1_resp_valid <= 1'b0;
            m1_resp_data  <= '0;
            m1_resp_last  <= 1'b0;
            bus_respack   <= 1'b0;
            err_tag       <= 1'b0;
        end else begin
            m0_req_ready  <= 1'b0;
            m1_req_ready  <= 1'b0;
            m0_resp_valid <= 1'b0;
            m0_resp_data  <= '0;
            m0_resp_last  <= 1'b0;
            m1_resp_valid <= 1'b0;
            m1_resp_data  <= '0;
            m1_resp_last  <= 1'b0;
            bus_respack   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        owner        <= gnt_id;
                        line_addr    <= {sel_addr[63:6], 6'b0};
                        m0_req_ready <= ~gnt_id;
                        m1_req_ready <= gnt_id;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_reqack) begin
                        beat_cnt <= '0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    bus_respack <= bus_respcyc;
                    if (bus_respcyc) begin
                        if (owner) begin
                            m1_resp_valid <= 1'b1;
                            m1_resp_data  <= bus_resp;
                            m1_resp_last  <= beat_last;
                        end else begin
                            m0_resp_valid <= 1'b1;
                            m0_resp_data  <= bus_resp;
                            m0_resp_last  <= beat_last;
                        end
                        beat_cnt <= beat_cnt + 1'b1;
                        // A mistagged beat is still the owner's data; only flag it.
                        if (bus_resptag[0] != owner) begin
                            err_tag <= 1'b1;
                        end
                        if (beat_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    bus_respack <= bus_respcyc;
                    if (bus_respcyc) begin
                        err_tag <= 1'b1;
                    end else begin
                        rr_ptr <= ~owner;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sysbus_fetch_arbiter.md
Name: sysbus_fetch_arbiter

Overview:
- Shares the single Sysbus master port between two read requesters: m0 (instruction fetch) and m1 (data/load path).
- Each grant issues one read request for a 64-byte line, collects N_BEATS response beats and routes them to the owning requester.
- Sits between the core front-end/load unit and the top-level bus pins.
- Arbitration is round-robin. Only one transaction is in flight at a time.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req / bus_resp and of the beat data returned to requesters
- BUS_TAG_WIDTH, 13, width of bus_reqtag / bus_resptag
- N_BEATS, 8, response beats per line (8 x 64 bit = 64 bytes)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_req_valid  in  1  m0 requests a line read
- m0_req_addr  in  64  line address (low 6 bits ignored and forced to 0 on the bus)
- m0_req_ready  out  1  one-cycle pulse: m0 request accepted and address latched
- m0_resp_valid  out  1  beat valid for m0
- m0_resp_data  out  BUS_DATA_WIDTH  beat data
- m0_resp_last  out  1  final beat of the line
- m1_*  same five ports as m0, for requester 1
- bus_reqcyc  out  1  Sysbus request cycle
- bus_req  out  BUS_DATA_WIDTH  request address
- bus_reqtag  out  BUS_TAG_WIDTH  request tag
- bus_reqack  in  1  bus accepted request
- bus_respcyc  in  1  response beat present
- bus_resp  in  BUS_DATA_WIDTH  response beat data
- bus_resptag  in  BUS_TAG_WIDTH  response tag
- bus_respack  out  1  response acknowledge
- err_tag  out  1  sticky: response tag id did not match the owner

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr = 0 (m0 preferred).
- Reset mid-transaction abandons the transaction. The bus model resets in the same cycle.
- IDLE, arbitration:
  - If only one req_valid is high, grant that requester.
  - If both are high, grant the requester named by rr_ptr.
  - In the grant cycle, pulse mX_req_ready for exactly 1 cycle, latch {addr[63:6],6'b0} and owner id, then go to REQ.
- REQ:
  - bus_reqcyc = 1, bus_req = latched address.
  - bus_reqtag = (SYSBUS_READ<<8)|(SYSBUS_MEMORY<<12)|owner_id (bit 0).
  - Hold until bus_reqack = 1. In that cycle, drop bus_reqcyc on the next edge, clear beat_cnt and go to RESP.
  - Request 1 cycle after grant at the earliest.
- RESP:
  - Each cycle with bus_respcyc = 1 is one beat. The bus never presents a beat in the reqack cycle.
  - Beat handling, registered 1-cycle latency:
    - owner's resp_valid <= 1
    - resp_data <= bus_resp
    - resp_last <= (beat_cnt == N_BEATS-1)
    - beat_cnt increments
  - Other requester's outputs stay 0.
  - bus_respack <= bus_respcyc (registered).
  - If bus_resptag[0] != owner_id, set err_tag and still deliver the beat to the owner.
  - After beat N_BEATS, go to DRAIN.
- DRAIN:
  - bus_respack stays 1 until bus_respcyc = 0. Then bus_respack <= 0, rr_ptr <= ~owner_id, and go to IDLE.
  - Extra beats seen in DRAIN are dropped and set err_tag.
- Next grant happens the cycle after returning to IDLE. Minimum gap between two bus requests: reqack, N_BEATS beats, drain, 1 idle cycle.
- beat_cnt is $clog2(N_BEATS)+1 bits wide and cannot wrap within a line.
- A req_valid that drops before grant is ignored. Requesters must hold valid/addr until ready.
- err_tag clears only on reset.

Decomposition:
- Package sysbus_pkg holds:
  - SYSBUS_READ and SYSBUS_MEMORY tag-field constants, matching Sysbus.defs
  - state enum {IDLE, REQ, RESP, DRAIN}
  - tag build function
- One sub-module is natural: rr_arbiter2. It is combinational grant logic from two valids plus rr_ptr, returning grant id and grant-valid.

Test Plan:
- m0 only, addr 0x1000_0044, bus acks after 3 cycles, 8 beats 0x11..0x88 -> bus_req = 0x1000_0040, tag = 0x1100; m0 gets 8 valid beats in order, last on 0x88; m1 outputs remain 0.
- Both requesting from reset -> m0 granted first; after DRAIN, m1 granted with tag low bit 1; m1 line delivered; m0 re-requests and waits until m1 completes.
- respcyc gaps: beats on cycles 1,2,5,6,7,9,10,11 -> beat_cnt advances only on beats; last asserted only with the 8th beat; respack follows respcyc by 1 cycle.
- resptag id mismatch (bit 0 = 1 while owner is m0) -> beat still delivered to m0; err_tag = 1 and stays 1 through later clean transactions.
- reset asserted during RESP after 4 beats -> next cycle all outputs 0, state IDLE; a following m1 request completes normally with 8 beats.
- bus_reqack held low for 20 cycles -> bus_reqcyc and bus_req stable for all 20 cycles; no m0_req_ready pulse beyond the grant cycle.
